// File: rtl/serializer_ctrl.sv
// Two-requester word serializer that drives an external 74165 shift register.
// Round-robin accepts a byte, strobes the parallel load, and clocks out 8 bits.
module serializer_ctrl #(
   parameter int CLK_DIV    = 2,
   parameter int GAP_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        valid0,
   input  logic        valid1,
   input  logic [7:0]  data0,
   input  logic [7:0]  data1,
   output logic        ready0,
   output logic        ready1,
   output logic [7:0]  par_data,
   output logic        par_load_n,
   output logic        ser_clk,
   output logic        frame,
   output logic        grant_ch,
   output logic        busy,
   output logic [15:0] words_sent
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

   if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_div
      $error("serializer_ctrl: CLK_DIV out of range 1..255");
   end
   if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
      $error("serializer_ctrl: GAP_CYCLES out of range 1..255");
   end

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic        ser_clk_q, ser_clk_d;
   logic        load_n_q, load_n_d;
   logic        frame_q, frame_d;
   logic        ready0_q, ready0_d;
   logic        ready1_q, ready1_d;
   logic [7:0]  data_q, data_d;
   logic        grant_q, grant_d;
   logic        prio_q, prio_d;
   logic        armed_q, armed_d;
   logic        busy_q, busy_d;
   logic [15:0] words_q, words_d;
   logic        pick;

   // prio: channel preferred when both request (0 = ch0).
   function automatic logic pick_ch(input logic v0, input logic v1, input logic pri);
      return (v0 && v1) ? pri : v1;
   endfunction

   assign pick = pick_ch(valid0, valid1, prio_q);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      ser_clk_d = 1'b0;
      load_n_d  = 1'b1;
      frame_d   = frame_q;
      ready0_d  = 1'b0;
      ready1_d  = 1'b0;
      data_d    = data_q;
      grant_d   = grant_q;
      prio_d    = prio_q;
      words_d   = words_q;
      // armed_q blocks acceptance on the first edge after reset releases
      armed_d   = 1'b1;

      case (state_q)
         IDLE: begin
            if (armed_q && enable && (valid0 || valid1)) begin
               grant_d  = pick;
               prio_d   = ~pick;
               data_d   = pick ? data1 : data0;
               ready0_d = ~pick;
               ready1_d = pick;
               load_n_d = 1'b0;
               frame_d  = 1'b1;
               cnt_d    = 8'd0;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            load_n_d = 1'b0;
            frame_d  = 1'b1;
            if (cnt_q == DIV_LAST) begin
               load_n_d = 1'b1;
               cnt_d    = 8'd0;
               bit_d    = 3'd0;
               state_d  = SHIFT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         SHIFT: begin
            ser_clk_d = ser_clk_q;
            if (cnt_q == DIV_LAST) begin
               cnt_d     = 8'd0;
               ser_clk_d = ~ser_clk_q;
               if (ser_clk_q) begin
                  if (bit_q == 3'd7) begin
                     frame_d = 1'b0;
                     words_d = words_q + 16'd1;
                     state_d = GAP;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = 8'd0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         bit_q     <= 3'd0;
         ser_clk_q <= 1'b0;
         load_n_q  <= 1'b1;
         frame_q   <= 1'b0;
         ready0_q  <= 1'b0;
         ready1_q  <= 1'b0;
         data_q    <= 8'h00;
         grant_q   <= 1'b0;
         prio_q    <= 1'b0;
         armed_q   <= 1'b0;
         busy_q    <= 1'b0;
         words_q   <= 16'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         ser_clk_q <= ser_clk_d;
         load_n_q  <= load_n_d;
         frame_q   <= frame_d;
         ready0_q  <= ready0_d;
         ready1_q  <= ready1_d;
         data_q    <= data_d;
         grant_q   <= grant_d;
         prio_q    <= prio_d;
         armed_q   <= armed_d;
         busy_q    <= busy_d;
         words_q   <= words_d;
      end
   end

   // The 74165 loads asynchronously, so a shift edge during load would corrupt the word.
   a_load_no_shift: assert property (@(posedge clk) disable iff (!reset_n)
      !load_n_q |-> !ser_clk_q);

   assign ready0     = ready0_q;
   assign ready1     = ready1_q;
   assign par_data   = data_q;
   assign par_load_n = load_n_q;
   assign ser_clk    = ser_clk_q;
   assign frame      = frame_q;
   assign grant_ch   = grant_q;
   assign busy       = busy_q;
   assign words_sent = words_q;

endmodule

// File: tb/tb_serializer_ctrl.sv
// Bench for serializer_ctrl: timeline reference model plus 74165 shift-out model,
// directed scenarios and randomized traffic; a second instance covers counter wrap.
module tb_serializer_ctrl;

   localparam int CD   = 2;
   localparam int GP   = 2;
   localparam int SEND = 17 * CD;
   localparam int WEND = 17 * CD + GP;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, en, v0, v1;
   logic [7:0] d0, d1;
   logic r0_a, r1_a, pl_a, sc_a, fr_a, gc_a, bz_a;
   logic [7:0] pd_a;
   logic [15:0] ws_a;

   logic rst_b, en_b, v0_b, v1_b;
   logic [7:0] d0_b, d1_b;
   logic r0_b, r1_b, pl_b, sc_b, fr_b, gc_b, bz_b;
   logic [7:0] pd_b;
   logic [15:0] ws_b;

   serializer_ctrl #(.CLK_DIV(CD), .GAP_CYCLES(GP)) dut_a (
      .clk(clk), .reset_n(rst_n), .enable(en), .valid0(v0), .valid1(v1),
      .data0(d0), .data1(d1), .ready0(r0_a), .ready1(r1_a), .par_data(pd_a),
      .par_load_n(pl_a), .ser_clk(sc_a), .frame(fr_a), .grant_ch(gc_a),
      .busy(bz_a), .words_sent(ws_a));

   serializer_ctrl #(.CLK_DIV(1), .GAP_CYCLES(1)) dut_b (
      .clk(clk), .reset_n(rst_b), .enable(en_b), .valid0(v0_b), .valid1(v1_b),
      .data0(d0_b), .data1(d1_b), .ready0(r0_b), .ready1(r1_b), .par_data(pd_b),
      .par_load_n(pl_b), .ser_clk(sc_b), .frame(fr_b), .grant_ch(gc_b),
      .busy(bz_b), .words_sent(ws_b));

   int checks, failures;
   int cyc;
   bit cmp_on;

   // reference model: word timeline measured in cycles since acceptance
   bit m_act, m_armed, m_has_last, m_last, m_rdy, m_ch;
   int m_k;
   logic [7:0] m_data;
   logic [15:0] m_words;

   // external 74165 and event bookkeeping
   logic [7:0] sreg, rx;
   int rx_n, rise_cnt, low_cnt, r0_cnt, r1_cnt;
   int fall_t[$];
   int fallb_t[$];
   bit gq[$];
   logic pl_prev, sc_prev, plb_prev;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   initial begin
      int n, b_r0, b_rise, b_low, b_f, b_g;
      logic [15:0] exp_w;
      rst_n = 0; en = 0; v0 = 0; v1 = 0; d0 = 0; d1 = 0;
      rst_b = 0; en_b = 0; v0_b = 0; v1_b = 0; d0_b = 0; d1_b = 0;
      checks = 0; failures = 0; cyc = 0; cmp_on = 0;
      m_act = 0; m_armed = 0; m_has_last = 0; m_last = 0; m_rdy = 0; m_ch = 0;
      m_k = 0; m_data = 0; m_words = 0;
      sreg = 0; rx = 0; rx_n = 0; rise_cnt = 0; low_cnt = 0; r0_cnt = 0; r1_cnt = 0;
      pl_prev = 1; sc_prev = 0; plb_prev = 1;

      fork
         forever begin
            @(posedge clk);
            cyc++;
            if (rst_n === 1'b0) begin
               m_act = 0; m_armed = 0; m_has_last = 0; m_last = 0; m_rdy = 0;
               m_ch = 0; m_k = 0; m_data = 8'h00; m_words = 16'd0;
            end else begin
               m_rdy = 0;
               if (m_act) begin
                  m_k++;
                  if (m_k == SEND) m_words = m_words + 16'd1;
                  if (m_k == WEND) m_act = 0;
               end else if (m_armed && en && (v0 || v1)) begin
                  if (v0 && v1) m_ch = m_has_last ? !m_last : 1'b0;
                  else m_ch = v1;
                  m_last = m_ch; m_has_last = 1;
                  m_data = m_ch ? d1 : d0;
                  m_act = 1; m_k = 0; m_rdy = 1;
               end
               m_armed = 1;
            end
         end
         forever begin
            logic e_pl, e_sc, e_fr;
            @(negedge clk);
            if (pl_a === 1'b0) begin
               sreg = pd_a; rx = 8'h00; rx_n = 0;
            end else if (sc_a === 1'b1 && sc_prev === 1'b0) begin
               rx = {rx[6:0], sreg[7]};
               sreg = {sreg[6:0], 1'b0};
               rx_n++; rise_cnt++;
            end
            if (pl_prev === 1'b1 && pl_a === 1'b0) fall_t.push_back(cyc);
            if (pl_a === 1'b0) low_cnt++;
            if (r0_a === 1'b1) r0_cnt++;
            if (r1_a === 1'b1) r1_cnt++;
            if (r0_a === 1'b1 || r1_a === 1'b1) gq.push_back(r1_a);
            pl_prev = pl_a; sc_prev = sc_a;
            if (plb_prev === 1'b1 && pl_b === 1'b0) fallb_t.push_back(cyc);
            plb_prev = pl_b;
            if (cmp_on) begin
               e_pl = !(m_act && m_k < CD);
               e_sc = m_act && m_k >= CD && m_k < SEND && (((m_k - CD) / CD) % 2 == 1);
               e_fr = m_act && m_k < SEND;
               chk("par_load_n", 32'(pl_a), 32'(e_pl));
               chk("ser_clk", 32'(sc_a), 32'(e_sc));
               chk("frame", 32'(fr_a), 32'(e_fr));
               chk("busy", 32'(bz_a), 32'(m_act));
               chk("ready0", 32'(r0_a), 32'(m_rdy && !m_ch));
               chk("ready1", 32'(r1_a), 32'(m_rdy && m_ch));
               chk("grant_ch", 32'(gc_a), 32'(m_ch));
               chk("par_data", 32'(pd_a), 32'(m_data));
               chk("words_sent", 32'(ws_a), 32'(m_words));
               if (m_act && m_k == SEND) begin
                  chk("ser_word", 32'(rx), 32'(m_data));
                  chk("ser_bits", 32'(rx_n), 32'd8);
               end
            end
         end
         begin
            #2000000;
            $display("FAIL watchdog actual=timeout required=finish");
            $fatal(1, "watchdog");
         end
      join_none

      // reset state
      tick(); tick();
      cmp_on = 1;
      chk("rst_par_load_n", 32'(pl_a), 32'd1);
      chk("rst_ser_clk", 32'(sc_a), 32'd0);
      chk("rst_frame", 32'(fr_a), 32'd0);
      chk("rst_busy", 32'(bz_a), 32'd0);
      chk("rst_par_data", 32'(pd_a), 32'h00);
      chk("rst_grant", 32'(gc_a), 32'd0);
      chk("rst_words", 32'(ws_a), 32'd0);
      chk("rst_ready0", 32'(r0_a), 32'd0);

      // acceptance guard after reset release, then reset mid-shift
      en = 1; v0 = 1; d0 = 8'h5A;
      rst_n = 1;
      tick();
      chk("acc_guard_ready0", 32'(r0_a), 32'd0);
      tick();
      chk("first_accept_ready0", 32'(r0_a), 32'd1);
      v0 = 0;
      b_rise = rise_cnt;
      n = 0;
      while (rise_cnt - b_rise < 4 && n < 200) begin tick(); n++; end
      chk("midrst_4_rises", 32'(rise_cnt - b_rise), 32'd4);
      rst_n = 0;
      tick();
      chk("midrst_ser_clk", 32'(sc_a), 32'd0);
      chk("midrst_frame", 32'(fr_a), 32'd0);
      chk("midrst_busy", 32'(bz_a), 32'd0);
      chk("midrst_par_data", 32'(pd_a), 32'h00);
      chk("midrst_words", 32'(ws_a), 32'd0);
      rst_n = 1;

      // single word 0xA5
      b_r0 = r0_cnt; b_low = low_cnt; b_rise = rise_cnt;
      d0 = 8'hA5; v0 = 1;
      n = 0;
      while (r0_cnt == b_r0 && n < 20) begin tick(); n++; end
      v0 = 0;
      n = 0;
      while (bz_a !== 1'b0 && n < 100) begin tick(); n++; end
      chk("a5_ready0_pulses", 32'(r0_cnt - b_r0), 32'd1);
      chk("a5_load_low_cycles", 32'(low_cnt - b_low), 32'd2);
      chk("a5_rises", 32'(rise_cnt - b_rise), 32'd8);
      chk("a5_serial_bits", 32'(rx), 32'h000000A5);
      chk("a5_words", 32'(ws_a), 32'd1);

      // contention from fresh reset: alternating grants, 37-cycle load spacing
      rst_n = 0; tick(); rst_n = 1;
      d0 = 8'h11; d1 = 8'h22; v0 = 1; v1 = 1;
      b_g = gq.size(); b_f = fall_t.size();
      n = 0;
      while (gq.size() - b_g < 4 && n < 300) begin tick(); n++; end
      v0 = 0; v1 = 0;
      chk("rr_grant_count", 32'(gq.size() - b_g), 32'd4);
      if (gq.size() >= b_g + 4 && fall_t.size() >= b_f + 4) begin
         for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), 32'(gq[b_g + i]), 32'(i % 2));
         for (int i = 1; i < 4; i++)
            chk($sformatf("rr_period%0d", i), 32'(fall_t[b_f + i] - fall_t[b_f + i - 1]), 32'd37);
      end
      n = 0;
      while (bz_a !== 1'b0 && n < 100) begin tick(); n++; end
      chk("rr_words", 32'(ws_a), 32'd4);

      // enable drop during the 3rd ser_clk period
      b_r0 = r0_cnt; b_rise = rise_cnt;
      d0 = 8'h3C; v0 = 1;
      n = 0;
      while (r0_cnt == b_r0 && n < 20) begin tick(); n++; end
      b_f = fall_t.size();
      n = 0;
      while (!(rise_cnt - b_rise >= 2 && sc_a === 1'b0) && n < 100) begin tick(); n++; end
      en = 0;
      n = 0;
      while (bz_a !== 1'b0 && n < 100) begin tick(); n++; end
      for (int i = 0; i < 40; i++) tick();
      chk("endrop_rises", 32'(rise_cnt - b_rise), 32'd8);
      chk("endrop_words", 32'(ws_a), 32'd5);
      chk("endrop_no_new_load", 32'(fall_t.size() - b_f), 32'd0);
      chk("endrop_ready_pulses", 32'(r0_cnt - b_r0), 32'd1);
      v0 = 0; en = 1;

      // data stability after acceptance
      b_r0 = r0_cnt;
      d0 = 8'hC3; v0 = 1;
      n = 0;
      while (r0_cnt == b_r0 && n < 20) begin tick(); n++; end
      v0 = 0;
      tick();
      d0 = 8'hFF;
      n = 0;
      while (bz_a !== 1'b0 && n < 100) begin tick(); n++; end
      chk("stable_serial", 32'(rx), 32'h000000C3);
      chk("stable_words", 32'(ws_a), 32'd6);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(0, 399) != 0);
         en    = ($urandom_range(0, 9) != 0);
         v0    = ($urandom_range(0, 2) != 0);
         v1    = ($urandom_range(0, 2) != 0);
         d0    = 8'($urandom);
         d1    = 8'($urandom);
         tick();
      end
      rst_n = 1; en = 0; v0 = 0; v1 = 0;
      tick();

      // counter wrap on the CLK_DIV=1, GAP=1 instance
      rst_b = 1;
      tick(); tick();
      force dut_b.words_q = 16'hFFFD;
      tick();
      release dut_b.words_q;
      tick();
      chk("wrap_preset", 32'(ws_b), 32'h0000FFFD);
      en_b = 1; v0_b = 1; d0_b = 8'h96;
      exp_w = 16'hFFFD;
      for (int w = 0; w < 3; w++) begin
         n = 0;
         while (fr_b !== 1'b1 && n < 40) begin tick(); n++; end
         while (fr_b !== 1'b0 && n < 80) begin tick(); n++; end
         chk("wrap_word_done", 32'(n < 80), 32'd1);
         exp_w = exp_w + 16'd1;
         chk($sformatf("wrap_count%0d", w), 32'(ws_b), 32'(exp_w));
      end
      chk("wrap_zero", 32'(ws_b), 32'h00000000);
      v0_b = 0; en_b = 0;
      n = 0;
      while (bz_b !== 1'b0 && n < 40) begin tick(); n++; end
      chk("wrap_load_count", 32'(fallb_t.size() >= 3), 32'd1);
      if (fallb_t.size() >= 3) begin
         chk("wrap_period1", 32'(fallb_t[fallb_t.size()-1] - fallb_t[fallb_t.size()-2]), 32'd19);
         chk("wrap_period2", 32'(fallb_t[fallb_t.size()-2] - fallb_t[fallb_t.size()-3]), 32'd19);
      end
      chk("wrap_idle_busy", 32'(bz_b), 32'd0);
      chk("wrap_idle_ser_clk", 32'(sc_b), 32'd0);
      chk("wrap_par_data", 32'(pd_b), 32'h00000096);
      chk("wrap_grant", 32'(gc_b), 32'd0);
      chk("wrap_ready0", 32'(r0_b), 32'd0);
      chk("wrap_ready1", 32'(r1_b), 32'd0);
      chk("wrap_load_n", 32'(pl_b), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serializer_ctrl.md
SERIALIZER_CTRL -- requirements
Module: serializer_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, clk cycles per ser_clk half-period; legal range 1..255.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, idle cycles between words; legal range 1..255.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; one clock, synchronous, active-low.
REQ-005 SHALL have port enable  input  1  permits new word starts.
REQ-006 SHALL have ports valid0/valid1  input  1 each  requester word available.
REQ-007 SHALL have ports data0/data1  input  8 each  requester word.
REQ-008 SHALL have ports ready0/ready1  output  1 each  one-cycle accept pulse.
REQ-009 SHALL have port par_data  output  8  word presented to the external 74165 parallel inputs.
REQ-010 SHALL have port par_load_n  output  1  74165 load strobe; low means load.
REQ-011 SHALL have port ser_clk  output  1  74165 shift clock; shift on its rising edge.
REQ-012 SHALL have port frame  output  1  high while a word is on the serial line.
REQ-013 SHALL have port grant_ch  output  1  channel of the current or last word.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port words_sent  output  16  count of completed words.

Function
REQ-016 SHALL implement states IDLE, LOAD, SHIFT, GAP.
REQ-017 IDLE: if enable=1 and valid0 or valid1, the next edge SHALL capture the granted data into par_data, pulse that ready for exactly one cycle, set grant_ch, drive par_load_n=0, and enter LOAD.
REQ-018 Arbitration SHALL be round-robin: if both valids are high, grant the channel not granted last; a single valid SHALL be granted immediately; after reset ch0 has priority.
REQ-019 LOAD SHALL last CLK_DIV cycles with par_load_n=0, ser_clk=0, frame=1, then enter SHIFT with par_load_n=1.
REQ-020 SHIFT SHALL produce exactly 8 ser_clk periods, each CLK_DIV cycles low then CLK_DIV cycles high (8 rising edges, 16*CLK_DIV cycles), with a 3-bit bit counter, frame=1 throughout, and par_load_n=1.
REQ-021 At the end of the 8th high phase, ser_clk SHALL return to 0, frame SHALL go to 0, words_sent SHALL increment (wrapping 0xFFFF->0x0000), and the state SHALL become GAP.
REQ-022 GAP SHALL last GAP_CYCLES cycles with ser_clk=0, par_load_n=1, frame=0, then return to IDLE.
REQ-023 par_data SHALL hold its captured value from acceptance until the next acceptance.
REQ-024 Valid or data changes after acceptance SHALL have no effect on the word in flight; valid dropped before grant SHALL cause no capture.
REQ-025 enable=0 mid-word SHALL NOT abort the word: the word and its GAP complete, then IDLE holds.
REQ-026 par_load_n=0 and a ser_clk rising edge SHALL never coincide; ser_clk SHALL be 0 whenever par_load_n=0.
REQ-027 The back-to-back word period SHALL be 1 + CLK_DIV*17 + GAP_CYCLES cycles.

Reset
REQ-028 reset_n=0 at a clock edge SHALL set: state IDLE, par_load_n=1, ser_clk=0, frame=0, ready0=ready1=0, busy=0, par_data=0x00, grant_ch=0, words_sent=0, ch0 priority, and all counters to 0.
REQ-029 Reset mid-word SHALL abort immediately with no increment of words_sent and no ready pulse; the first post-reset acceptance SHALL occur no earlier than the second edge after reset_n rises.

Verification
REQ-030 Bench SHALL cover single word: CLK_DIV=2, GAP=2, valid0=1, data0=0xA5 -> ready0 one pulse; par_load_n low for 2 cycles; 8 ser_clk rises; external 74165 model emits 1,0,1,0,0,1,0,1 sampled before each rise; words_sent=1.
REQ-031 Bench SHALL cover contention: valid0=valid1=1 held, data0=0x11, data1=0x22 -> grants alternate ch0,ch1,ch0,ch1; par_load_n falling edges exactly 37 cycles apart.
REQ-032 Bench SHALL cover enable drop: enable->0 during the 3rd ser_clk period -> word completes (8 rises, frame falls); no new par_load_n pulse while enable=0 despite valid.
REQ-033 Bench SHALL cover reset mid-shift: reset_n=0 for 1 cycle after the 4th ser_clk rise -> next cycle ser_clk=0, frame=0, busy=0, par_data=0x00, words_sent unchanged from its pre-word value of 0.
REQ-034 Bench SHALL cover counter wrap: force 65536 words with CLK_DIV=1, GAP=1 -> words_sent wraps to 0x0000; per-word period 19 cycles.
REQ-035 Bench SHALL cover data stability: change data0 to 0xFF one cycle after ready0 -> serial output is still the originally captured value.
